seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage beside the combinational add/sub datapath. It is the subtract-and-shift counterpart of that datapath.
- Takes one operation per start/done handshake. Latency is fixed at XLEN+1 cycles. The pipeline stalls on busy.

Parameters:
- XLEN, 32, operand/result width and iteration count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  input  XLEN  rs1 value, sampled with start
- divisor  input  XLEN  rs2 value, sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  quotient or remainder, held until the next accepted start

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE; busy=0, done=0, result=0; internal counter and registers cleared.
  - Reset mid-operation abandons the operation; no done is produced.
- States:
  - IDLE --start--> CALC.
  - CALC: XLEN cycles; at count=XLEN-1 --> FIN.
  - FIN: one cycle --> IDLE.
- Accept, edge E0 (start=1 in IDLE):
  - Latch op.
  - Signed ops: take |dividend| and |divisor|; latch neg_q = sign(dividend)^sign(divisor) and neg_r = sign(dividend).
  - Clear partial remainder; counter=0; busy=1.
- CALC, edges E1..E32, one step per edge:
  - rem' = {rem[XLEN-2:0], q_msb}; shift the quotient register left.
  - If rem' >= divisor_mag: rem = rem' - divisor_mag and the new quotient LSB = 1; else rem = rem' and the LSB = 0.
  - The subtract is XLEN+1 bits wide; the borrow bit decides the compare.
- Edge E33 (leaving FIN):
  - result registered; done=1 for exactly the following cycle; busy=0 from the same edge.
  - A new start is accepted in that done cycle; back-to-back throughput is one op per XLEN+2 cycles.
- Sign fix-up (signed ops only):
  - quotient negated if neg_q; remainder negated if neg_r.
  - Two's complement, truncated to XLEN.
- Special cases: result per the RISC-V spec, same fixed latency, no early-out.
  - divisor=0: quotient = all ones (DIV and DIVU); remainder = original dividend (REM and REMU).
  - Signed overflow (dividend=0x80000000, divisor=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
  - The natural datapath yields the divide-by-zero results when no sign fix-up is applied to the zero case. The overflow case falls out of the magnitude arithmetic with truncation. Both are checked explicitly in FIN regardless, so the result never depends on the datapath happening to produce them.
- start while busy=1: ignored, operands not sampled, no error flag.
- op/dividend/divisor changing during CALC: no effect on the operation in progress.
- No back-pressure on done: the consumer must take result on the pulse or read the held value later.

Decomposition:
- Shared package div_pkg:
  - op encodings DIV_OP_DIV=2'b00, DIV_OP_DIVU=2'b01, DIV_OP_REM=2'b10, DIV_OP_REMU=2'b11.
  - state encoding DIV_IDLE, DIV_CALC, DIV_FIN.
  - DIV_LATENCY = XLEN+1.
- One sub-module: div_restore_step, combinational.
  - Inputs: rem, q_msb, divisor_mag.
  - Outputs: next rem, quotient bit.
  - Instantiated once in CALC.
- Counter, sign handling and FSM stay in seq_divider.

Test Plan:
1. DIVU 100/7, then REMU 100/7 -> result=14, then 2. Each time: done high exactly 33 cycles after the start edge; busy high for those 33 cycles.
2. DIV -7/2 (0xFFFFFFF9, 0x00000002) -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). REM 7/-2 -> 1.
3. Divide by zero:
   - DIV 5/0 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF.
   - REM 5/0 -> 5; REMU 0x80000000/0 -> 0x80000000.
   - Latency unchanged at 33 cycles.
4. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
5. Handshake:
   - Pulse start again at cycle 10 of a DIVU 1000/10, with different operands -> ignored; result=100, single done pulse.
   - New start issued in the done cycle -> accepted; second done 33 cycles later.
6. Reset mid-operation:
   - Drop rst_n at cycle 15 of an operation -> busy, done and result = 0 immediately (asynchronous); no done pulse afterwards.
   - After release, DIVU 9/3 -> 3.

Source files
------------

// File: rtl/div_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared encodings and constants for the sequential divider
//  Revision : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int DIV_XLEN    = 32;
    localparam int DIV_LATENCY = DIV_XLEN + 1;

    // funct3[1:0] of the RV32M divide group
    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIN  = 2'd2
    } div_state_e;

    // Bit 0 clear selects the signed variants (DIV, REM)
    function automatic logic div_op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Bit 1 set selects the remainder variants (REM, REMU)
    function automatic logic div_op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq_divider_if
//  Purpose  : start/done request bus between the execute stage and divider
//  Revision : 1.0  initial release
// ============================================================================
interface seq_divider_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, dividend, divisor,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/div_restore_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : div_restore_step
//  Purpose  : One combinational shift/compare/subtract step of restoring
//             division
//  Revision : 1.0  initial release
// ============================================================================
module div_restore_step #(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] i_rem,
    input  wire logic            i_q_msb,
    input  wire logic [XLEN-1:0] i_divisor_mag,
    output logic      [XLEN-1:0] o_rem,
    output logic                 o_q_bit
);

    logic [XLEN-1:0] w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;

    // Shift the next dividend bit in, then trial-subtract one bit wider so
    // the borrow acts as the compare. If the remainder's MSB is shifted out,
    // the true shifted value is at least 2^XLEN and therefore exceeds any
    // divisor; the low XLEN bits of the difference are still exact.
    always_comb begin
        w_shift = {i_rem[XLEN-2:0], i_q_msb};
        w_diff  = {1'b0, w_shift} - {1'b0, i_divisor_mag};
        w_ge    = i_rem[XLEN-1] | ~w_diff[XLEN];
        o_rem   = w_ge ? w_diff[XLEN-1:0] : w_shift;
        o_q_bit = w_ge;
    end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU,
//             fixed latency of XLEN+1 cycles from accept to done
//  Revision : 1.0  initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    seq_divider_if.slave bus
);

    localparam int              c_CNT_W = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] c_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;
    logic               r_ovf;
    logic [XLEN-1:0]    r_dvd;
    logic [XLEN-1:0]    r_dsr_mag;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic               r_busy;
    logic               r_done;
    logic [XLEN-1:0]    r_result;

    logic               w_signed;
    logic [XLEN-1:0]    w_dvd_mag;
    logic [XLEN-1:0]    w_dsr_mag;
    logic [XLEN-1:0]    w_rem_next;
    logic               w_q_bit;
    logic [XLEN-1:0]    w_fin_result;

    // Operand magnitudes for the accept edge; unsigned ops pass straight through
    always_comb begin
        w_signed  = div_op_is_signed(bus.op);
        w_dvd_mag = (w_signed && bus.dividend[XLEN-1]) ? -bus.dividend : bus.dividend;
        w_dsr_mag = (w_signed && bus.divisor[XLEN-1])  ? -bus.divisor  : bus.divisor;
    end

    div_restore_step #(
        .XLEN (XLEN)
    ) u_step (
        .i_rem         (r_rem),
        .i_q_msb       (r_quo[XLEN-1]),
        .i_divisor_mag (r_dsr_mag),
        .o_rem         (w_rem_next),
        .o_q_bit       (w_q_bit)
    );

    // Final result selection: the two architected corner cases are forced
    // explicitly, otherwise apply the sign fix-up to quotient or remainder
    always_comb begin
        w_fin_result = '0;
        if (r_div_zero) begin
            w_fin_result = div_op_is_rem(r_op) ? r_dvd : '1;
        end else if (r_ovf) begin
            w_fin_result = div_op_is_rem(r_op) ? '0 : c_MIN;
        end else if (div_op_is_rem(r_op)) begin
            w_fin_result = r_neg_r ? -r_rem : r_rem;
        end else begin
            w_fin_result = r_neg_q ? -r_quo : r_quo;
        end
    end

    // Control FSM and datapath registers; the quotient register starts as the
    // dividend magnitude and is shifted out MSB-first as quotient bits enter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= DIV_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_dvd      <= '0;
            r_dsr_mag  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                DIV_IDLE: begin
                    if (bus.start) begin
                        r_state    <= DIV_CALC;
                        r_busy     <= 1'b1;
                        r_op       <= bus.op;
                        r_neg_q    <= w_signed & (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
                        r_neg_r    <= w_signed & bus.dividend[XLEN-1];
                        r_div_zero <= (bus.divisor == '0);
                        r_ovf      <= w_signed && (bus.dividend == c_MIN) && (bus.divisor == '1);
                        r_dvd      <= bus.dividend;
                        r_dsr_mag  <= w_dsr_mag;
                        r_quo      <= w_dvd_mag;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                    end
                end
                DIV_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[XLEN-2:0], w_q_bit};
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= DIV_FIN;
                    end
                end
                DIV_FIN: begin
                    r_result <= w_fin_result;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Directed self-checking bench for seq_divider
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;
    import div_pkg::*;

    localparam int c_LAT = 33;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seq_divider_if #(.XLEN(32)) bus ();

    seq_divider #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge, hold it across one rising edge (E0),
    // then scramble the operand inputs so later changes are shown to be inert
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.op       = 2'($urandom);
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    // Watch negedges after E0; negedge j follows edge E(j). Optionally inject
    // a one-cycle start pulse with other operands at negedge inject_at.
    task automatic wait_result(input string tag, input int inject_at);
        int          busy_cnt;
        bit          seen;
        logic [31:0] exp;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (bus.start) bus.start = 1'b0;
            if (bus.done) begin
                chk({tag, " latency"}, 32'(j), 32'(c_LAT));
                chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(c_LAT));
                chk({tag, " busy at done"}, 32'(bus.busy), 32'd0);
                chk({tag, " scoreboard depth"}, 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    chk({tag, " result"}, bus.result, exp);
                end
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (j == inject_at) begin
                bus.start    = 1'b1;
                bus.op       = DIV_OP_DIVU;
                bus.dividend = 32'd77;
                bus.divisor  = 32'd5;
            end
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL %s done timeout: observed=no done expected=done within 100 cycles", tag);
        end
    endtask

    // No done pulse and idle over a window
    task automatic quiet(input string tag, input int n);
        int d;
        d = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) d++;
        end
        chk({tag, " stray done"}, 32'(d), 32'd0);
        chk({tag, " busy idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{DIV_OP_REMU, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{DIV_OP_DIV,  32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD};
        vecs[3]  = '{DIV_OP_REM,  32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFF};
        vecs[4]  = '{DIV_OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1};
        vecs[5]  = '{DIV_OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14};
        vecs[6]  = '{DIV_OP_REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE};
        vecs[7]  = '{DIV_OP_DIVU, 32'hFFFFFFFF,   32'h80000001,   32'd1};
        vecs[8]  = '{DIV_OP_REMU, 32'hFFFFFFFF,   32'h80000001,   32'h7FFFFFFE};
        vecs[9]  = '{DIV_OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF};
        vecs[10] = '{DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF};
        vecs[11] = '{DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF};
        vecs[12] = '{DIV_OP_REM,  32'd5,          32'd0,          32'd5};
        vecs[13] = '{DIV_OP_REMU, 32'h80000000,   32'd0,          32'h80000000};
        vecs[14] = '{DIV_OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000};
        vecs[15] = '{DIV_OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = '0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset busy",   32'(bus.busy), 32'd0);
        chk("reset done",   32'(bus.done), 32'd0);
        chk("reset result", bus.result,    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Arithmetic table, including divide-by-zero and signed overflow
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
            wait_result($sformatf("vec%0d", i), -1);
            @(negedge clk);
            chk($sformatf("vec%0d done width", i), 32'(bus.done), 32'd0);
        end

        // Start while busy is ignored; a start in the done cycle is accepted
        issue(DIV_OP_DIVU, 32'd1000, 32'd10, 32'd100);
        wait_result("ignored start", 10);
        issue(DIV_OP_REMU, 32'd1000, 32'd7, 32'd6);
        wait_result("back to back", -1);
        quiet("after b2b", 40);

        // Asynchronous reset mid-operation
        issue(DIV_OP_DIVU, 32'd12345, 32'd3, 32'd4115);
        repeat (15) @(negedge clk);
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset busy",   32'(bus.busy), 32'd0);
        chk("async reset done",   32'(bus.done), 32'd0);
        chk("async reset result", bus.result,    32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet("after reset", 40);

        issue(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3);
        wait_result("post reset divu", -1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
